dsp_mac_sequencer: RTL and testbench

Streaming multiply-accumulate controller that drives a DSP48A1-style slice from the fabric side. It accepts (a, b) operand pairs over a valid/ready handshake and issues them to the slice with correctly timed OPMODE words. It collects the slice's P output after every TAPS products and returns each 48-bit sum over a second valid/ready handshake. It is the initiator for the slice: the slice computes, and this block sequences, aligns latency and handles backpressure.

---
 rtl/dsp_mac_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Fabric-side sequencer for a DSP48A1-style MAC slice: issues operand pairs with aligned
// OPMODE words, captures every TAPS-product sum from P and buffers it in a 2-deep result FIFO.
module dsp_mac_sequencer #(
    parameter int TAPS    = 4,
    parameter int MUL_LAT = 2,
    parameter int OP_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_data,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    output logic        busy
);

    localparam int CNT_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OP_DLY  = MUL_LAT - OP_LAT;
    localparam int CAP_LEN = MUL_LAT + 2;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_tap_cnt, w_tap_cnt_nxt;
    logic               w_in_hs, w_first_tap, w_last_tap;
    logic               w_first_at_op, w_first_pend;
    logic               w_push, w_pop;
    int                 w_outstanding;

    logic               r_ce, r_dsp_rst;
    logic [17:0]        r_dsp_a_p0, r_dsp_b_p0;
    logic [7:0]         r_opmode;
    logic [CAP_LEN-1:0] r_last_p;
    logic [47:0]        r_fifo [2];
    logic               r_wptr, r_rptr;
    logic [1:0]         r_fifo_cnt;

    assign w_in_hs = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tap_cnt <= w_tap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tap_cnt_nxt = r_tap_cnt;
        w_first_tap   = 1'b0;
        w_last_tap    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_first_tap = 1'b1;
                    if (TAPS == 1) begin
                        w_last_tap = 1'b1;
                    end else begin
                        w_state_nxt   = S_ACC;
                        w_tap_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            S_ACC: begin
                if (w_in_hs) begin
                    if (r_tap_cnt == CNT_W'(TAPS - 1)) begin
                        w_last_tap    = 1'b1;
                        w_state_nxt   = S_IDLE;
                        w_tap_cnt_nxt = '0;
                    end else begin
                        w_tap_cnt_nxt = r_tap_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: operands into the slice; idle slots issue zeros so P simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce       <= 1'b0;
            r_dsp_rst  <= 1'b1;
            r_dsp_a_p0 <= '0;
            r_dsp_b_p0 <= '0;
            r_last_p   <= '0;
        end else begin
            r_ce       <= 1'b1;
            r_dsp_rst  <= 1'b0;
            r_dsp_a_p0 <= w_in_hs ? in_a : '0;
            r_dsp_b_p0 <= w_in_hs ? in_b : '0;
            r_last_p   <= (r_last_p << 1) | CAP_LEN'(w_last_tap);
        end
    end

    // First-tap flag is delayed so the zero-Z opmode meets its own product at the post-adder.
    generate
        if (OP_DLY == 0) begin : g_op_direct
            assign w_first_at_op = w_first_tap;
            assign w_first_pend  = 1'b0;
        end else begin : g_op_line
            logic [OP_DLY-1:0] r_first_p;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_first_p <= '0;
                else        r_first_p <= (r_first_p << 1) | OP_DLY'(w_first_tap);
            end
            assign w_first_at_op = r_first_p[OP_DLY-1];
            assign w_first_pend  = |r_first_p;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_opmode <= OPM_FIRST;
        else        r_opmode <= w_first_at_op ? OPM_FIRST : OPM_ACC;
    end

    // Capture stage: the last-tap flag emerges one edge after P has registered the full sum.
    assign w_push = r_last_p[CAP_LEN-1];
    assign w_pop  = res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= dsp_p;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // A group may only start if its result is guaranteed a FIFO slot; a pop this cycle counts.
    always_comb begin
        w_outstanding = int'(r_fifo_cnt);
        for (int i = 0; i < CAP_LEN; i++) w_outstanding = w_outstanding + int'(r_last_p[i]);
        if (w_pop) w_outstanding = w_outstanding - 1;
        in_ready = r_ce && ((r_state == S_ACC) || (w_outstanding < 2));
    end

    assign res_valid  = (r_fifo_cnt != 2'd0);
    assign res_data   = r_fifo[r_rptr];
    assign dsp_a      = r_dsp_a_p0;
    assign dsp_b      = r_dsp_b_p0;
    assign dsp_opmode = r_opmode;
    assign dsp_ce     = r_ce;
    assign dsp_rst    = r_dsp_rst;
    assign busy       = (r_state == S_ACC) || (|r_last_p) || w_first_pend || res_valid;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (TAPS=4 and TAPS=1), each driving a behavioural
// DSP48A1 slice, with directed scenarios followed by random traffic against a sum scoreboard.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [17:0] in_a      [2];
    logic [17:0] in_b      [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [47:0] res_data  [2];
    logic [17:0] dsp_a     [2];
    logic [17:0] dsp_b     [2];
    logic [7:0]  dsp_opmode[2];
    logic        dsp_ce    [2];
    logic        dsp_rst   [2];
    logic [47:0] dsp_p     [2];
    logic        busy      [2];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ntap0 = 0, ntap1 = 0;
    logic [47:0] got0[$];
    logic [47:0] got1[$];
    int          got1_edge[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mac_sequencer #(.TAPS(4), .MUL_LAT(2), .OP_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .dsp_a(dsp_a[0]), .dsp_b(dsp_b[0]), .dsp_opmode(dsp_opmode[0]),
        .dsp_ce(dsp_ce[0]), .dsp_rst(dsp_rst[0]), .dsp_p(dsp_p[0]), .busy(busy[0]));

    dsp_mac_sequencer #(.TAPS(1), .MUL_LAT(2), .OP_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .dsp_a(dsp_a[1]), .dsp_b(dsp_b[1]), .dsp_opmode(dsp_opmode[1]),
        .dsp_ce(dsp_ce[1]), .dsp_rst(dsp_rst[1]), .dsp_p(dsp_p[1]), .busy(busy[1]));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int TK = (k == 0) ? 4 : 1;
        // Slice: A1/B1 regs, M reg, OPMODE reg, P reg; X=M when opmode[1:0]=01, Z=P when [3:2]=10.
        logic [17:0] s_a1, s_b1;
        logic [35:0] s_m;
        logic [7:0]  s_op;
        logic [47:0] s_p;
        always @(posedge clk) begin
            if (dsp_rst[k]) begin
                s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_op <= '0; s_p <= '0;
            end else if (dsp_ce[k]) begin
                s_a1 <= dsp_a[k];
                s_b1 <= dsp_b[k];
                s_m  <= s_a1 * s_b1;
                s_op <= dsp_opmode[k];
                s_p  <= ((s_op[3:2] == 2'b10) ? s_p : 48'd0)
                      + ((s_op[1:0] == 2'b01) ? {12'd0, s_m} : 48'd0) + {47'd0, s_op[5]};
            end
        end
        assign dsp_p[k] = s_p;

        // Reference: sum of TK accepted products per result, delivered in acceptance order.
        logic [47:0] exp_q[$];
        logic [47:0] acc;
        int          nt;
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc = '0;
                nt  = 0;
            end else begin
                if (res_valid[k] && res_ready[k]) begin
                    chk_eq($sformatf("sb%0d_avail", k), 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) chk_eq($sformatf("sb%0d_data", k), res_data[k], exp_q.pop_front());
                end
                if (in_valid[k] && in_ready[k]) begin
                    acc = ((nt == 0) ? 48'd0 : acc) + 48'(in_a[k]) * 48'(in_b[k]);
                    nt++;
                    if (nt == TK) begin
                        exp_q.push_back(acc);
                        nt = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            got0.delete(); got1.delete(); got1_edge.delete();
            ntap0 = 0; ntap1 = 0;
        end else begin
            if (res_valid[0] && res_ready[0]) got0.push_back(res_data[0]);
            if (res_valid[1] && res_ready[1]) begin
                got1.push_back(res_data[1]);
                got1_edge.push_back(cyc + 1);
            end
            if (in_valid[0] && in_ready[0]) ntap0++;
            if (in_valid[1] && in_ready[1]) ntap1++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tap(input int k, input logic [17:0] a, input logic [17:0] b, inout int stalls);
        int waited = 0;
        in_valid[k] = 1'b1;
        in_a[k] = a;
        in_b[k] = b;
        forever begin
            @(negedge clk);
            if (in_ready[k]) begin
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            waited++;
            if (waited > 60) begin
                chk_eq("tap_timeout", 64'(in_ready[k]), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_res(input int k, output int n);
        n = 0;
        while (!res_valid[k] && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int st, n, base, highs;
        logic [17:0] ta, tb;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; res_ready[k] = 1'b1;
        end
        tick(3);
        chk_eq("rst_in_ready", 64'(in_ready[0]), 64'd0);
        chk_eq("rst_res_valid", 64'(res_valid[0]), 64'd0);
        chk_eq("rst_opmode", 64'(dsp_opmode[0]), 64'h01);
        chk_eq("rst_ce", 64'(dsp_ce[0]), 64'd0);
        chk_eq("rst_dsp_rst", 64'(dsp_rst[0]), 64'd1);
        chk_eq("rst_busy", 64'(busy[0]), 64'd0);
        rst_n = 1'b1;
        tick(1);
        chk_eq("rel_dsp_rst", 64'(dsp_rst[0]), 64'd0);
        chk_eq("rel_ce", 64'(dsp_ce[0]), 64'd1);
        chk_eq("rel_in_ready", 64'(in_ready[0]), 64'd1);
        chk_eq("rel_opmode", 64'(dsp_opmode[0]), 64'h09);

        // Back-to-back taps, result latency and no stalls
        st = 0;
        send_tap(0, 18'd1, 18'd2, st); send_tap(0, 18'd3, 18'd4, st);
        send_tap(0, 18'd5, 18'd6, st); send_tap(0, 18'd7, 18'd8, st);
        wait_res(0, n);
        chk_eq("t1_latency", 64'(n), 64'd4);
        chk_eq("t1_data", res_data[0], 48'd100);
        chk_eq("t1_stalls", 64'(st), 64'd0);
        tick(4);

        // Gaps of three idle cycles between taps
        for (int i = 0; i < 4; i++) begin
            send_tap(0, 18'(2 * i + 1), 18'(2 * i + 2), st);
            tick(3);
            if (i == 1) chk_eq("t2_busy_gap", 64'(busy[0]), 64'd1);
        end
        wait_res(0, n);
        chk_eq("t2_valid", 64'(res_valid[0]), 64'd1);
        chk_eq("t2_data", res_data[0], 48'd100);
        tick(4);

        // Maximum operands, then an immediate small group
        base = got0.size();
        for (int i = 0; i < 4; i++) send_tap(0, 18'h3FFFF, 18'h3FFFF, st);
        for (int i = 0; i < 4; i++) send_tap(0, 18'd1, 18'd1, st);
        tick(10);
        chk_eq("t3_count", 64'(got0.size() - base), 64'd2);
        if (got0.size() >= base + 2) begin
            chk_eq("t3_max", got0[base], 48'h3F_FFE0_0004);
            chk_eq("t3_small", got0[base + 1], 48'd4);
        end

        // Backpressure: credit exhausted after two buffered groups
        res_ready[0] = 1'b0;
        send_tap(0, 18'd1, 18'd2, st); send_tap(0, 18'd3, 18'd4, st);
        send_tap(0, 18'd5, 18'd6, st); send_tap(0, 18'd7, 18'd8, st);
        for (int i = 0; i < 4; i++) send_tap(0, 18'd1, 18'd1, st);
        in_valid[0] = 1'b1; in_a[0] = 18'd1; in_b[0] = 18'd1;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready[0]) highs++;
            @(posedge clk);
            #1;
        end
        chk_eq("t4_blocked", 64'(highs), 64'd0);
        chk_eq("t4_head_valid", 64'(res_valid[0]), 64'd1);
        chk_eq("t4_head", res_data[0], 48'd100);
        base = got0.size();
        res_ready[0] = 1'b1;
        for (int i = 1; i <= 4; i++) send_tap(0, 18'd1, 18'(i), st);
        tick(12);
        chk_eq("t4_count", 64'(got0.size() - base), 64'd3);
        if (got0.size() >= base + 3) begin
            chk_eq("t4_order0", got0[base], 48'd100);
            chk_eq("t4_order1", got0[base + 1], 48'd4);
            chk_eq("t4_order2", got0[base + 2], 48'd10);
        end

        // Reset mid-group
        send_tap(0, 18'd9, 18'd9, st); send_tap(0, 18'd9, 18'd9, st);
        chk_eq("t5_busy_pre", 64'(busy[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t5_in_ready", 64'(in_ready[0]), 64'd0);
        chk_eq("t5_res_valid", 64'(res_valid[0]), 64'd0);
        chk_eq("t5_res_data", res_data[0], 48'd0);
        chk_eq("t5_dsp_a", 64'(dsp_a[0]), 64'd0);
        chk_eq("t5_dsp_b", 64'(dsp_b[0]), 64'd0);
        chk_eq("t5_opmode", 64'(dsp_opmode[0]), 64'h01);
        chk_eq("t5_ce", 64'(dsp_ce[0]), 64'd0);
        chk_eq("t5_dsp_rst", 64'(dsp_rst[0]), 64'd1);
        chk_eq("t5_busy", 64'(busy[0]), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk_eq("t5_rel_ready", 64'(in_ready[0]), 64'd1);
        for (int i = 0; i < 4; i++) send_tap(0, 18'd1, 18'd1, st);
        wait_res(0, n);
        chk_eq("t5_data", res_data[0], 48'd4);
        tick(4);

        // TAPS=1 instance: one result per tap on consecutive cycles
        base = got1.size();
        send_tap(1, 18'd2, 18'd3, st);
        send_tap(1, 18'd4, 18'd5, st);
        tick(10);
        chk_eq("t6_count", 64'(got1.size() - base), 64'd2);
        if (got1.size() >= base + 2) begin
            chk_eq("t6_r0", got1[base], 48'd6);
            chk_eq("t6_r1", got1[base + 1], 48'd20);
            chk_eq("t6_spacing", 64'(got1_edge[base + 1] - got1_edge[base]), 64'd1);
        end

        // Random traffic on both instances
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = ($urandom_range(0, 2) != 0);
                in_a[k]      = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom);
                in_b[k]      = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom);
                res_ready[k] = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        res_ready[0] = 1'b1;
        res_ready[1] = 1'b1;
        while (ntap0 % 4 != 0) begin
            ta = 18'($urandom);
            tb = 18'($urandom);
            send_tap(0, ta, tb, st);
        end
        tick(12);
        chk_eq("drain0_busy", 64'(busy[0]), 64'd0);
        chk_eq("drain1_busy", 64'(busy[1]), 64'd0);
        chk_eq("drain0_valid", 64'(res_valid[0]), 64'd0);
        chk_eq("drain0_count", 64'(got0.size()), 64'(ntap0 / 4));
        chk_eq("drain1_count", 64'(got1.size()), 64'(ntap1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
